// File: rtl/mmio_decoder_v2.sv
// MMIO address decoder: splits data-bus accesses between cache and fixed-size MMIO slots,
// with a control window in slot 0 holding staged/committed window registers and a fault recorder.
module mmio_decoder_v2 #(
    parameter int          NUM_SLOTS      = 8,
    parameter int          SLOT_SIZE_LOG2 = 10,
    parameter logic [31:0] DEFAULT_BASE   = 32'h0020_0000,
    parameter logic [31:0] DEFAULT_BOUND  = 32'h0040_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               data_address,
    input  logic [31:0]               data_store,
    input  logic                      data_read,
    input  logic                      data_enable,
    input  logic [32*NUM_SLOTS-1:0]   slot_rdata,
    output logic [31:0]               data_fetch,
    output logic [NUM_SLOTS-1:0]      mmio_vector,
    output logic [NUM_SLOTS-1:0]      mmio_vector_ff,
    output logic                      cache_access,
    output logic                      cache_access_ff,
    output logic                      mmio_fault,
    output logic                      fault_pending
);

    localparam int          OW       = SLOT_SIZE_LOG2;
    localparam logic [32:0] MIN_SPAN = 33'(NUM_SLOTS) << SLOT_SIZE_LOG2;
    localparam logic [OW-1:0] OFS_BASE   = OW'(5'h00);
    localparam logic [OW-1:0] OFS_BOUND  = OW'(5'h04);
    localparam logic [OW-1:0] OFS_COMMIT = OW'(5'h08);
    localparam logic [OW-1:0] OFS_SLOTEN = OW'(5'h0C);
    localparam logic [OW-1:0] OFS_FADDR  = OW'(5'h10);
    localparam logic [OW-1:0] OFS_FCLR   = OW'(5'h14);

    logic [31:0]          base_q, base_d, bound_q, bound_d;
    logic [31:0]          stg_base_q, stg_base_d, stg_bound_q, stg_bound_d;
    logic [NUM_SLOTS-1:0] slot_en_q, slot_en_d;
    logic                 commit_rej_q, commit_rej_d;
    logic                 fault_pend_q, fault_pend_d;
    logic [31:0]          fault_addr_q, fault_addr_d;
    logic [31:0]          ctrl_rdata_q, ctrl_rdata_d;
    logic [NUM_SLOTS-1:0] vec_ff_q;
    logic                 cache_ff_q, fault_ff_q;

    logic        in_range, fault, ctrl_wr, ctrl_rd, commit_ok;
    logic [31:0] offset, slot_idx;
    logic [OW-1:0] ctrl_ofs;
    logic        unused_slot0;

    // Slot 0 is the internal control window; its device read-data field is never used.
    assign unused_slot0 = ^slot_rdata[31:0];

    always_comb begin
        mmio_vector = '0;
        in_range    = data_enable && (data_address >= base_q) && (data_address < bound_q);
        offset      = data_address - base_q;
        slot_idx    = offset >> SLOT_SIZE_LOG2;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            mmio_vector[i] = in_range && (slot_idx == 32'(i)) && slot_en_q[i];
        end
    end

    assign cache_access = data_enable & ~in_range;
    assign fault        = in_range & ~(|mmio_vector);
    assign ctrl_ofs     = offset[OW-1:0];
    assign ctrl_wr      = mmio_vector[0] & ~data_read;
    assign ctrl_rd      = mmio_vector[0] & data_read;
    // 33-bit span check so a huge bound minus a small base cannot wrap into a false pass.
    assign commit_ok    = (stg_base_q[OW-1:0] == '0) && (stg_bound_q > stg_base_q) &&
                          (({1'b0, stg_bound_q} - {1'b0, stg_base_q}) >= MIN_SPAN);

    always_comb begin
        base_d       = base_q;
        bound_d      = bound_q;
        stg_base_d   = stg_base_q;
        stg_bound_d  = stg_bound_q;
        slot_en_d    = slot_en_q;
        commit_rej_d = commit_rej_q;
        fault_addr_d = fault_addr_q;
        fault_pend_d = fault_pend_q;
        ctrl_rdata_d = '0;

        if (ctrl_wr) begin
            case (ctrl_ofs)
                OFS_BASE:   stg_base_d  = data_store;
                OFS_BOUND:  stg_bound_d = data_store;
                OFS_COMMIT: begin
                    if (data_store[0]) begin
                        if (commit_ok) begin
                            base_d       = stg_base_q;
                            bound_d      = stg_bound_q;
                            commit_rej_d = 1'b0;
                        end else begin
                            commit_rej_d = 1'b1;
                        end
                    end
                end
                OFS_SLOTEN: slot_en_d = data_store[NUM_SLOTS-1:0] | NUM_SLOTS'(1);
                OFS_FCLR:   fault_pend_d = 1'b0;
                default:    ;
            endcase
        end

        if (ctrl_rd) begin
            case (ctrl_ofs)
                OFS_BASE:   ctrl_rdata_d = stg_base_q;
                OFS_BOUND:  ctrl_rdata_d = stg_bound_q;
                OFS_COMMIT: ctrl_rdata_d = {30'b0, fault_pend_q, commit_rej_q};
                OFS_SLOTEN: ctrl_rdata_d = 32'(slot_en_q);
                OFS_FADDR:  ctrl_rdata_d = fault_addr_q;
                default:    ctrl_rdata_d = '0;
            endcase
        end

        // Fault is evaluated last so it overrides a same-cycle clear.
        if (fault) begin
            fault_pend_d = 1'b1;
            fault_addr_d = data_address;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= DEFAULT_BASE;
            bound_q      <= DEFAULT_BOUND;
            stg_base_q   <= DEFAULT_BASE;
            stg_bound_q  <= DEFAULT_BOUND;
            slot_en_q    <= '1;
            commit_rej_q <= 1'b0;
            fault_pend_q <= 1'b0;
            fault_addr_q <= '0;
            ctrl_rdata_q <= '0;
            vec_ff_q     <= '0;
            cache_ff_q   <= 1'b1;
            fault_ff_q   <= 1'b0;
        end else begin
            base_q       <= base_d;
            bound_q      <= bound_d;
            stg_base_q   <= stg_base_d;
            stg_bound_q  <= stg_bound_d;
            slot_en_q    <= slot_en_d;
            commit_rej_q <= commit_rej_d;
            fault_pend_q <= fault_pend_d;
            fault_addr_q <= fault_addr_d;
            ctrl_rdata_q <= ctrl_rdata_d;
            vec_ff_q     <= mmio_vector;
            cache_ff_q   <= cache_access;
            fault_ff_q   <= fault;
        end
    end

    always_comb begin
        data_fetch = '0;
        if (!(cache_ff_q || fault_ff_q)) begin
            if (vec_ff_q[0]) begin
                data_fetch = ctrl_rdata_q;
            end else begin
                for (int i = 1; i < NUM_SLOTS; i++) begin
                    if (vec_ff_q[i]) data_fetch = slot_rdata[32*i +: 32];
                end
            end
        end
    end

    assign mmio_vector_ff  = vec_ff_q;
    assign cache_access_ff = cache_ff_q;
    assign mmio_fault      = fault_ff_q;
    assign fault_pending   = fault_pend_q;

endmodule

// File: tb/tb_mmio_decoder_v2.sv
// Directed bench for mmio_decoder_v2 with default parameters (8 slots of 1 KiB).
module tb_mmio_decoder_v2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  data_address, data_store;
    logic         data_read, data_enable;
    logic [255:0] slot_rdata;
    logic [31:0]  data_fetch;
    logic [7:0]   mmio_vector, mmio_vector_ff;
    logic         cache_access, cache_access_ff, mmio_fault, fault_pending;

    int n_chk = 0;
    int n_bad = 0;

    mmio_decoder_v2 dut (
        .clk(clk), .rst_n(rst_n),
        .data_address(data_address), .data_store(data_store),
        .data_read(data_read), .data_enable(data_enable),
        .slot_rdata(slot_rdata), .data_fetch(data_fetch),
        .mmio_vector(mmio_vector), .mmio_vector_ff(mmio_vector_ff),
        .cache_access(cache_access), .cache_access_ff(cache_access_ff),
        .mmio_fault(mmio_fault), .fault_pending(fault_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic [31:0] a, input logic rd, input logic [31:0] d);
        @(negedge clk);
        data_address = a;
        data_read    = rd;
        data_store   = d;
        data_enable  = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        data_enable = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        acc(a, 1'b0, d);
        step();
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        acc(a, 1'b1, 32'h0);
        step();
        check(tag, data_fetch, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) slot_rdata[32*i +: 32] = 32'hA000_0000 + 32'(i);
        data_address = '0; data_store = '0; data_read = 1'b0; data_enable = 1'b0;
        do_reset();
        #1;
        check("rst_vec_ff", 32'(mmio_vector_ff), 32'h0);
        check("rst_cache_ff", 32'(cache_access_ff), 32'h1);
        check("rst_fault", 32'(mmio_fault), 32'h0);
        check("rst_pending", 32'(fault_pending), 32'h0);
        check("rst_fetch", data_fetch, 32'h0);

        // Default window 0x0020_0000..0x0040_0000: offset 0x800 is slot 2.
        acc(32'h0020_0800, 1'b1, 0);
        check("slot2_vec", 32'(mmio_vector), 32'h04);
        check("slot2_cache", 32'(cache_access), 32'h0);
        step();
        check("slot2_fetch", data_fetch, 32'hA000_0002);
        check("slot2_cache_ff", 32'(cache_access_ff), 32'h0);
        check("slot2_vec_ff", 32'(mmio_vector_ff), 32'h04);

        acc(32'h0000_1000, 1'b1, 0);
        check("cache_acc", 32'(cache_access), 32'h1);
        check("cache_vec", 32'(mmio_vector), 32'h0);
        step();
        check("cache_ff", 32'(cache_access_ff), 32'h1);
        check("cache_fetch", data_fetch, 32'h0);

        // Move the window; the commit access itself still decodes in the old window.
        wr(32'h0020_0000, 32'h0030_0000);
        wr(32'h0020_0004, 32'h0030_2000);
        acc(32'h0020_0008, 1'b0, 32'h1);
        check("commit_old_win", 32'(mmio_vector), 32'h01);
        step();
        rd_chk("status_ok", 32'h0030_0008, 32'h0);
        check("status_vec_ff", 32'(mmio_vector_ff), 32'h01);
        acc(32'h0030_0C00, 1'b1, 0);
        check("new_slot3_vec", 32'(mmio_vector), 32'h08);
        step();
        check("new_slot3_fetch", data_fetch, 32'hA000_0003);
        acc(32'h0020_0C00, 1'b1, 0);
        check("old_addr_cache", 32'(cache_access), 32'h1);
        acc(32'h0030_1FFC, 1'b1, 0);
        check("last_slot_vec", 32'(mmio_vector), 32'h80);
        acc(32'h0030_2000, 1'b1, 0);
        check("eq_bound_cache", 32'(cache_access), 32'h1);
        acc(32'h002F_FFFF, 1'b1, 0);
        check("below_base_cache", 32'(cache_access), 32'h1);

        // Misaligned staged base is rejected; decode unchanged.
        wr(32'h0030_0000, 32'h0030_0100);
        wr(32'h0030_0008, 32'h1);
        rd_chk("status_rej", 32'h0030_0008, 32'h1);
        rd_chk("stg_base_rb", 32'h0030_0000, 32'h0030_0100);
        acc(32'h0030_0C00, 1'b1, 0);
        check("rej_slot3_vec", 32'(mmio_vector), 32'h08);
        // Span smaller than 8 slots is rejected too.
        wr(32'h0030_0000, 32'h0050_0000);
        wr(32'h0030_0004, 32'h0050_1C00);
        wr(32'h0030_0008, 32'h1);
        acc(32'h0050_0000, 1'b1, 0);
        check("short_span_cache", 32'(cache_access), 32'h1);

        // Slot enables: bit 0 is forced on, disabled slot faults.
        wr(32'h0030_000C, 32'h0000_00FA);
        rd_chk("sloten_rb", 32'h0030_000C, 32'h0000_00FB);
        acc(32'h0030_0800, 1'b1, 0);
        check("dis_vec", 32'(mmio_vector), 32'h0);
        check("dis_cache", 32'(cache_access), 32'h0);
        step();
        check("dis_fault", 32'(mmio_fault), 32'h1);
        check("dis_pending", 32'(fault_pending), 32'h1);
        check("dis_fetch", data_fetch, 32'h0);
        idle();
        step();
        check("fault_pulse_end", 32'(mmio_fault), 32'h0);
        rd_chk("fault_addr", 32'h0030_0010, 32'h0030_0800);
        rd_chk("status_fp_rej", 32'h0030_0008, 32'h3);
        rd_chk("unmapped_ofs", 32'h0030_0020, 32'h0);
        wr(32'h0030_0014, 32'h0);
        check("fclr_pending", 32'(fault_pending), 32'h0);
        wr(32'h0030_000C, 32'hFFFF_FFFF);
        rd_chk("sloten_all", 32'h0030_000C, 32'h0000_00FF);

        // Back to defaults: offsets past 8 slots fault; reset mid-access clears everything.
        do_reset();
        acc(32'h0020_2400, 1'b1, 0);
        check("oob_vec", 32'(mmio_vector), 32'h0);
        step();
        check("oob_fault", 32'(mmio_fault), 32'h1);
        check("oob_pending", 32'(fault_pending), 32'h1);
        acc(32'h0020_0800, 1'b1, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vec_ff", 32'(mmio_vector_ff), 32'h0);
        check("mid_rst_cache_ff", 32'(cache_access_ff), 32'h1);
        check("mid_rst_fault", 32'(mmio_fault), 32'h0);
        check("mid_rst_pending", 32'(fault_pending), 32'h0);
        check("mid_rst_fetch", data_fetch, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_faddr", 32'h0020_0010, 32'h0);
        rd_chk("post_rst_stg", 32'h0020_0000, 32'h0020_0000);
        rd_chk("post_rst_slot2", 32'h0020_0800, 32'hA000_0002);
        idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
